// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable sequence detector.
// Contents: FSM state encoding and the legacy default pattern "1011".
// No logic; imported by the detector top and its benches.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Pattern of the fixed-function predecessor, kept for benches.
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
  localparam int         DEFAULT_LEN     = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used to count pattern matches.
// Latency: count reflects inc/clr on the edge after they are sampled.
// No backpressure: inc is ignored once the count is all-ones; clr wins over inc.
// Ports: clk, reset (async, active-high), inc, clr, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial-pattern detector with Mealy match output and match counter.
// Latency: q is combinational from inbit/in_valid; match_count/armed/cfg_err one edge later.
// No backpressure: every valid bit is consumed; a cfg_load in the same cycle discards the bit.
// Ports: clk, reset (async, active-high), inbit/in_valid (serial input),
//   cfg_load/cfg_pattern/cfg_len/cfg_overlap (run-time configuration), cnt_clr,
//   q (match), match_count, armed (state RUN), cfg_err (illegal length pulse).
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inbit,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             q,
  output logic [CNT_W-1:0] match_count,
  output logic             armed,
  output logic             cfg_err
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic             cfg_err_q;

  logic             cfg_legal;
  logic             cfg_accept;
  logic             accept_bit;
  logic [PAT_W-1:0] len_mask;
  logic [PAT_W:0]   window;
  logic             fill_ok;
  logic             pat_eq;
  logic             match;

  assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign cfg_accept = cfg_load && cfg_legal;

  // Configuration has priority over data: a bit arriving with any cfg_load is dropped.
  assign accept_bit = (state_q == RUN) && in_valid && !cfg_load;

  // Low len_q bits set; a shift by PAT_W yields all ones.
  assign len_mask = ~({PAT_W{1'b1}} << len_q);
  assign window   = {hist_q, inbit};

  // The current bit supplies one of the len bits, so len-1 stored bits suffice.
  assign fill_ok = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
  assign pat_eq  = ((window ^ {1'b0, pat_q}) & {1'b0, len_mask}) == '0;
  assign match   = accept_bit && fill_ok && pat_eq;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Only reset leaves RUN.
  always_comb begin
    state_d = state_q;
    if (cfg_accept) begin
      state_d = RUN;
    end
  end

  // FSM: outputs
  always_comb begin
    armed = (state_q == RUN);
    q     = match;
  end

  // Configuration and history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
    end else if (cfg_accept) begin
      pat_q  <= cfg_pattern;
      len_q  <= cfg_len;
      ovl_q  <= cfg_overlap;
      hist_q <= '0;
      fill_q <= '0;
    end else if (accept_bit) begin
      hist_q <= {hist_q[PAT_W-2:0], inbit};
      // Without overlap the matching bit must not seed the next match.
      if (match && !ovl_q) begin
        fill_q <= '0;
      end else if (fill_q < len_q) begin
        fill_q <= fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_load && !cfg_legal;
    end
  end

  assign cfg_err = cfg_err_q;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (cnt_clr || cfg_accept),
    .count(match_count)
  );

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Programmable serial-pattern detector with a Mealy match output. It is the parametrised successor to the fixed four-bit "1011" detector: pattern, pattern length and overlap mode are loaded at run time, input bits are qualified by a valid strobe, and matches are counted. It sits on the serial input path and feeds match pulses and a match count to downstream control logic.

## Interface
Parameters:
- PAT_W, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, match counter width (≥1)
- LEN_W, $clog2(PAT_W+1), width of the length field (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- inbit  in  1  serial data bit
- in_valid  in  1  inbit is consumed on this edge
- cfg_load  in  1  latch the configuration inputs on this edge
- cfg_pattern  in  PAT_W  pattern; bit len-1 is the first bit received, bit 0 the last
- cfg_len  in  LEN_W  pattern length; legal range is 1..PAT_W
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history restarts after a match
- cnt_clr  in  1  synchronous clear of match_count
- q  out  1  Mealy match; combinational, asserted during the cycle whose valid bit completes a match
- match_count  out  CNT_W  number of matches, saturating at all-ones
- armed  out  1  configured and detecting (state RUN)
- cfg_err  out  1  registered one-cycle pulse when cfg_load carries an illegal cfg_len

## Operation
- States: IDLE and RUN.
  - Reset enters IDLE.
  - IDLE → RUN on cfg_load with a legal length.
  - RUN → RUN on any legal cfg_load (reconfigure).
  - There is no transition back to IDLE except reset.
- Accepted cfg_load:
  - Latches pattern, length and overlap.
  - Clears hist, fill and match_count.
  - Not counted as a match.
- Illegal cfg_load (cfg_len = 0 or > PAT_W):
  - Configuration, state and counters are unchanged.
  - cfg_err = 1 for the next cycle.
- History:
  - hist is a PAT_W-bit shift register; each valid bit shifts in at the LSB.
  - fill counts valid bits since the last clear and saturates at len.
- Match condition: state = RUN, in_valid = 1, fill ≥ len−1, and the low len bits of {hist, inbit} equal the low len bits of the pattern.
- After a match:
  - overlap = 1: fill continues to advance normally.
  - overlap = 0: fill is set to 0 on that edge, so the matching bit cannot start the next match.
- In IDLE, or when in_valid = 0:
  - q = 0.
  - hist and fill hold.
- If cfg_load and in_valid occur in the same cycle, the configuration wins: the bit is discarded and q = 0.
- match_count:
  - Increments by 1 on each match edge, holding at 2^CNT_W−1.
  - If cnt_clr coincides with a match, clear wins and the count is 0.
- len = 1: every valid bit equal to pattern[0] matches.

## Timing
- Reset values: q=0, match_count=0, armed=0, cfg_err=0, hist=0, fill=0, configuration=0.
- q has zero latency from inbit/in_valid (combinational), gated by registered state only.
- match_count, armed and cfg_err update on the clock edge after the qualifying event.
- A reset asserted mid-stream clears everything asynchronously:
  - q drops immediately.
  - A new cfg_load is required before detection resumes.

## Structure
- Shared package seq_det_pkg:
  - state typedef enum logic {IDLE, RUN}.
  - Default-pattern constant 4'b1011 for benches.
- Sub-module sat_counter (parameter W; ports inc, clr, count) implements the saturating match counter.
- All other logic stays in the top module.

## Test plan
- Overlap on: cfg pattern=...1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 → q high on bits 4 and 7; match_count=2.
- Overlap off: same stream with overlap=0 → q high on bit 4 only; match_count=1.
- Valid gaps: 1011 sent with in_valid low for 3 cycles between bits, inbit toggling during the gaps → exactly one q pulse, on the last valid bit.
- Illegal config: cfg_load with len=0, then with len=PAT_W+1 → cfg_err pulses once each; armed stays 0; q stays 0 for 1011.
- Counter behaviour:
  - With CNT_W=2, seven matches → count reads 3.
  - cnt_clr in the same cycle as a match → count=0.
- Reset mid-pattern: reset after 1,0,1 → q=0 and all outputs at reset values; after reset, 1 alone produces no match; armed=0 until cfg_load.
